irq_timer_ctrl: RTL and testbench

IRQ_TIMER_CTRL -- requirements
Module: irq_timer_ctrl

---
 rtl/irq_timer_ctrl.sv | 149 ++++++++++++++
 tb/tb_irq_timer_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/irq_timer_ctrl.sv
// Memory-mapped timer with reload, overflow flag and interrupt sequencer.
// Registers TH/TL/TCON sit at BASE; irq is gated off while pc_31 is high.
module irq_timer_ctrl #(
  parameter logic [31:0] BASE = 32'h40000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic        pc_31,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } state_t;

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic        r_ten;
  logic        r_tie;
  logic        r_tif;
  state_t      r_state;

  logic        w_hit_th;
  logic        w_hit_tl;
  logic        w_hit_tc;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tc;
  logic [31:0] w_tl_nxt;
  logic        w_ovf;
  logic        w_tif_nxt;
  state_t      w_state_nxt;

  assign w_hit_th = (addr == BASE);
  assign w_hit_tl = (addr == BASE + 32'h4);
  assign w_hit_tc = (addr == BASE + 32'h8);
  assign w_wr_th  = wr_en && w_hit_th;
  assign w_wr_tl  = wr_en && w_hit_tl;
  assign w_wr_tc  = wr_en && w_hit_tc;

  // Counter next value; a software write to TL masks any overflow.
  always_comb begin
    w_tl_nxt = r_tl;
    w_ovf    = 1'b0;
    if (w_wr_tl) begin
      w_tl_nxt = wdata;
    end else if (r_ten) begin
      if (r_tl == 32'hFFFFFFFF) begin
        w_tl_nxt = r_th;
        w_ovf    = 1'b1;
      end else begin
        w_tl_nxt = r_tl + 32'h1;
      end
    end
  end

  // Flag next value; hardware set outranks a software clear.
  always_comb begin
    w_tif_nxt = r_tif;
    if (w_wr_tc && !wdata[2]) begin
      w_tif_nxt = 1'b0;
    end
    if (w_ovf) begin
      w_tif_nxt = 1'b1;
    end
  end

  // Timer register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th  <= 32'h0;
      r_tl  <= 32'h0;
      r_ten <= 1'b0;
      r_tie <= 1'b0;
      r_tif <= 1'b0;
    end else begin
      if (w_wr_th) begin
        r_th <= wdata;
      end
      r_tl  <= w_tl_nxt;
      r_tif <= w_tif_nxt;
      if (w_wr_tc) begin
        r_ten <= wdata[0];
        r_tie <= wdata[1];
      end
    end
  end

  // Combinational read mux over the three mapped registers.
  always_comb begin
    rdata = 32'h0;
    if (rd_en) begin
      if (w_hit_th) begin
        rdata = r_th;
      end else if (w_hit_tl) begin
        rdata = r_tl;
      end else if (w_hit_tc) begin
        rdata = {29'h0, r_tif, r_tie, r_ten};
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer next-state logic from registered flag/enable.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (r_tif && r_tie) begin
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        if (pc_31) begin
          w_state_nxt = SERV;
        end else if (!r_tie || !r_tif) begin
          w_state_nxt = IDLE;
        end
      end
      SERV: begin
        if (!pc_31) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request is held off whenever the CPU is already in kernel mode.
  always_comb begin
    irq = (r_state == PEND) && !pc_31;
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl.
// Inputs change 1ns after posedge; checks sample between edges.
module tb_irq_timer_ctrl;

  localparam logic [31:0] BASE = 32'h40000000;
  localparam logic [31:0] A_TH = BASE;
  localparam logic [31:0] A_TL = BASE + 32'h4;
  localparam logic [31:0] A_TC = BASE + 32'h8;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr_en;
  logic        rd_en;
  logic        pc_31;
  logic [31:0] rdata;
  logic        irq;

  int checks;
  int errors;

  irq_timer_ctrl #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .pc_31 (pc_31),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    rd_en = 1'b0;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    addr  = a;
    rd_en = 1'b1;
    #1;
    chk(tag, rdata, exp);
    rd_en = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'h0, irq}, {31'h0, exp});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    addr   = 32'h0;
    wdata  = 32'h0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    pc_31  = 1'b0;
    #2;
    rd("rst_th", A_TH, 32'h0);
    rd("rst_tl", A_TL, 32'h0);
    rd("rst_tc", A_TC, 32'h0);
    chk_irq("rst_irq", 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    rd("rel_th", A_TH, 32'h0);
    rd("rel_tl", A_TL, 32'h0);
    rd("rel_tc", A_TC, 32'h0);

    // Reload/overflow/irq latency sequence.
    wr(A_TH, 32'hFFFFFFF0);
    rd("th_wr", A_TH, 32'hFFFFFFF0);
    rd("unmapped", BASE + 32'hC, 32'h0);
    wr(A_TL, 32'hFFFFFFFE);
    wr(A_TC, 32'h3);
    rd("tl_e0", A_TL, 32'hFFFFFFFE);
    chk_irq("irq_e0", 1'b0);
    tick();
    rd("tl_e1", A_TL, 32'hFFFFFFFF);
    chk_irq("irq_e1", 1'b0);
    tick();
    rd("tl_e2", A_TL, 32'hFFFFFFF0);
    rd("tc_e2", A_TC, 32'h7);
    chk_irq("irq_e2", 1'b0);
    tick();
    chk_irq("irq_e3", 1'b1);
    rd("tl_e3", A_TL, 32'hFFFFFFF1);

    // Kernel entry masks irq; software clear then return.
    pc_31 = 1'b1;
    #1;
    chk_irq("irq_pc31", 1'b0);
    tick();
    chk_irq("irq_serv", 1'b0);
    wr(A_TL, 32'h0);
    wr(A_TC, 32'h3);
    rd("tc_clr", A_TC, 32'h3);
    pc_31 = 1'b0;
    tick();
    chk_irq("irq_ret0", 1'b0);
    tick();
    chk_irq("irq_ret1", 1'b0);

    // Return without clearing the flag re-raises irq.
    wr(A_TL, 32'hFFFFFFFF);
    tick();
    rd("tc_ovf2", A_TC, 32'h7);
    tick();
    chk_irq("irq_pend2", 1'b1);
    pc_31 = 1'b1;
    tick();
    pc_31 = 1'b0;
    #1;
    chk_irq("irq_serv2", 1'b0);
    tick();
    chk_irq("irq_idle2", 1'b0);
    tick();
    chk_irq("irq_rearm", 1'b1);
    wr(A_TC, 32'h3);
    tick();
    chk_irq("irq_drop", 1'b0);

    // Software write to TL beats a same-cycle overflow.
    wr(A_TL, 32'hFFFFFFFF);
    wr(A_TL, 32'h5);
    rd("tl_win", A_TL, 32'h5);
    rd("tc_win", A_TC, 32'h3);
    tick();
    chk_irq("irq_win", 1'b0);
    rd("tl_win1", A_TL, 32'h6);

    // Overflow beats a same-cycle TCON clear.
    wr(A_TL, 32'hFFFFFFFF);
    wr(A_TC, 32'h3);
    rd("tc_race", A_TC, 32'h7);
    rd("tl_race", A_TL, 32'hFFFFFFF0);

    // Reset while pending abandons everything.
    wr(A_TL, 32'h1234);
    chk_irq("irq_pre_rst", 1'b1);
    rd("tl_pre_rst", A_TL, 32'h1234);
    #1;
    reset = 1'b0;
    #1;
    chk_irq("irq_async", 1'b0);
    rd("tl_async", A_TL, 32'h0);
    rd("tc_async", A_TC, 32'h0);
    rd("th_async", A_TH, 32'h0);
    tick();
    #2;
    reset = 1'b1;
    tick();
    tick();
    tick();
    rd("tl_hold", A_TL, 32'h0);
    rd("tc_hold", A_TC, 32'h0);
    chk_irq("irq_hold", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
